// File: rtl/mpsoc_dbg_core_ctrl_reg.sv
// ============================================================================
// mpsoc_dbg_core_ctrl_reg
//
// Purpose:
//   Per-core debug control for every core in the tile array, in the single CPU
//   clock domain. Each core n (flat index ((x*Y + y)*Z + z)*CORES_PER_TILE + t)
//   has:
//     - stall_reg[n] : host-controlled stall request, forced to 1 on breakpoint
//                      and on single-step completion
//     - bp_stat[n]   : sticky breakpoint status, write-1-to-clear
//     - step engine  : IDLE/RUN FSM that releases a stalled core for exactly
//                      STEP_CYCLES CPU cycles, then re-stalls it
//
// Register map (reg_addr_i):
//   0 STALL  : R/W, stall_reg
//   1 BPSTAT : R/W1C, bp_stat
//   2 STEP   : W starts a step per set bit, R returns the run vector
//   3 STATUS : R effective stall (cpu_stall_o); writes load xt_mask when the
//              cross-trigger option is built in, otherwise are ignored
//
// Optional feature (compile-time macro DBG_CROSS_TRIGGER_EN):
//   Adds xt_mask. A breakpoint on any masked core stalls every masked core and
//   aborts their steps on the next edge. bp_stat only records a core's own
//   breakpoint, and only the firing core gets the combinational stall.
//
// Ports:
//   cpu_clk_i    in   1       CPU clock, the only clock
//   cpu_rst_i    in   1       synchronous active-high reset
//   reg_we_i     in   1       host register write strobe (one cycle)
//   reg_addr_i   in   2       register address
//   reg_wdata_i  in   NCORES  write data, one bit per core
//   reg_rdata_o  out  NCORES  read data for reg_addr_i (combinational)
//   bp_i         in   NCORES  per-core breakpoint pulse/level
//   cpu_stall_o  out  NCORES  per-core stall request
//   step_busy_o  out  NCORES  core is executing a single step
//   halt_o       out  1       OR of all bp_stat bits
// ============================================================================
module mpsoc_dbg_core_ctrl_reg #(
    parameter int X              = 2,
    parameter int Y              = 2,
    parameter int Z              = 2,
    parameter int CORES_PER_TILE = 1,
    parameter int STEP_CYCLES    = 1,
    localparam int NCORES        = X * Y * Z * CORES_PER_TILE,
    localparam int CNT_W         = $clog2(STEP_CYCLES + 1)
) (
    input  logic              cpu_clk_i,
    input  logic              cpu_rst_i,
    input  logic              reg_we_i,
    input  logic [1:0]        reg_addr_i,
    input  logic [NCORES-1:0] reg_wdata_i,
    output logic [NCORES-1:0] reg_rdata_o,
    input  logic [NCORES-1:0] bp_i,
    output logic [NCORES-1:0] cpu_stall_o,
    output logic [NCORES-1:0] step_busy_o,
    output logic              halt_o
);

    localparam logic [1:0] ADDR_STALL  = 2'd0;
    localparam logic [1:0] ADDR_BPSTAT = 2'd1;
    localparam logic [1:0] ADDR_STEP   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } step_state_t;

    logic              wr_stall;
    logic              wr_bpstat;
    logic              wr_step;

    logic [NCORES-1:0] stall_q;
    logic [NCORES-1:0] stall_d;
    logic [NCORES-1:0] bp_stat_q;
    logic [NCORES-1:0] bp_stat_d;

    // hit: breakpoint seen by a lane, either its own or a cross-trigger
    logic [NCORES-1:0] hit;
    logic [NCORES-1:0] step_done;
    logic [NCORES-1:0] run_vec;

    step_state_t       state_q [NCORES];
    step_state_t       state_d [NCORES];
    logic [CNT_W-1:0]  cnt_q   [NCORES];
    logic [CNT_W-1:0]  cnt_d   [NCORES];

    assign wr_stall  = reg_we_i && (reg_addr_i == ADDR_STALL);
    assign wr_bpstat = reg_we_i && (reg_addr_i == ADDR_BPSTAT);
    assign wr_step   = reg_we_i && (reg_addr_i == ADDR_STEP);

`ifdef DBG_CROSS_TRIGGER_EN
    logic [NCORES-1:0] xt_mask_q;
    logic              wr_xt;
    logic              xt_fire;

    assign wr_xt   = reg_we_i && (reg_addr_i == ADDR_STATUS);
    assign xt_fire = |(xt_mask_q & bp_i);

    always_ff @(posedge cpu_clk_i) begin
        if (cpu_rst_i) begin
            xt_mask_q <= '0;
        end else if (wr_xt) begin
            xt_mask_q <= reg_wdata_i;
        end
    end

    assign hit = bp_i | (xt_mask_q & {NCORES{xt_fire}});
`else
    assign hit = bp_i;
`endif

    // ------------------------------------------------------------------
    // Step engine: next state per lane
    // ------------------------------------------------------------------
    // A breakpoint in the same cycle as a STEP write wins: the core stays
    // stalled rather than starting a step that would be aborted at once.
    always_comb begin
        for (int n = 0; n < NCORES; n++) begin
            state_d[n]   = state_q[n];
            cnt_d[n]     = cnt_q[n];
            step_done[n] = 1'b0;
            run_vec[n]   = (state_q[n] == ST_RUN);
            case (state_q[n])
                ST_IDLE: begin
                    if (wr_step && reg_wdata_i[n] && stall_q[n] && !hit[n]) begin
                        state_d[n] = ST_RUN;
                        cnt_d[n]   = CNT_W'(STEP_CYCLES);
                    end
                end
                ST_RUN: begin
                    if (hit[n]) begin
                        state_d[n] = ST_IDLE;
                        cnt_d[n]   = '0;
                    end else if (cnt_q[n] == CNT_W'(1)) begin
                        // Last run cycle: the counter counts run cycles left
                        // including the current one, so RUN lasts STEP_CYCLES.
                        state_d[n]   = ST_IDLE;
                        cnt_d[n]     = '0;
                        step_done[n] = 1'b1;
                    end else begin
                        cnt_d[n] = cnt_q[n] - CNT_W'(1);
                    end
                end
                default: begin
                    state_d[n] = ST_IDLE;
                    cnt_d[n]   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Step engine: state register
    // ------------------------------------------------------------------
    always_ff @(posedge cpu_clk_i) begin
        for (int n = 0; n < NCORES; n++) begin
            if (cpu_rst_i) begin
                state_q[n] <= ST_IDLE;
                cnt_q[n]   <= '0;
            end else begin
                state_q[n] <= state_d[n];
                cnt_q[n]   <= cnt_d[n];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stall and breakpoint status registers
    // ------------------------------------------------------------------
    // Breakpoint and step completion force the bit to 1, so they can be
    // OR-ed over the host write path instead of an explicit priority chain.
    // A STALL write during RUN only changes stall_reg; the step continues.
    always_comb begin
        stall_d   = hit | step_done | (wr_stall ? reg_wdata_i : stall_q);
        // Set wins over a same-cycle write-1-to-clear.
        bp_stat_d = bp_i | (bp_stat_q & ~(wr_bpstat ? reg_wdata_i : '0));
    end

    always_ff @(posedge cpu_clk_i) begin
        if (cpu_rst_i) begin
            stall_q   <= '0;
            bp_stat_q <= '0;
        end else begin
            stall_q   <= stall_d;
            bp_stat_q <= bp_stat_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // bp_i stalls its own core combinationally; a running step masks the
    // registered stall so the core executes during RUN.
    assign cpu_stall_o = bp_i | (stall_q & ~run_vec);
    assign step_busy_o = run_vec;
    assign halt_o      = |bp_stat_q;

    always_comb begin
        reg_rdata_o = '0;
        case (reg_addr_i)
            ADDR_STALL:  reg_rdata_o = stall_q;
            ADDR_BPSTAT: reg_rdata_o = bp_stat_q;
            ADDR_STEP:   reg_rdata_o = run_vec;
            ADDR_STATUS: reg_rdata_o = cpu_stall_o;
            default:     reg_rdata_o = '0;
        endcase
    end

endmodule

// File: tb/tb_mpsoc_dbg_core_ctrl_reg.sv
module tb_mpsoc_dbg_core_ctrl_reg;

    localparam int N     = 8;
    localparam int STEPS = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         we;
    logic [1:0]   addr;
    logic [N-1:0] wd;
    logic [N-1:0] bp;
    logic [N-1:0] rdata;
    logic [N-1:0] stall_o;
    logic [N-1:0] busy_o;
    logic         halt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mpsoc_dbg_core_ctrl_reg #(
        .X(2), .Y(2), .Z(2), .CORES_PER_TILE(1), .STEP_CYCLES(STEPS)
    ) dut (
        .cpu_clk_i   (clk),
        .cpu_rst_i   (rst),
        .reg_we_i    (we),
        .reg_addr_i  (addr),
        .reg_wdata_i (wd),
        .reg_rdata_o (rdata),
        .bp_i        (bp),
        .cpu_stall_o (stall_o),
        .step_busy_o (busy_o),
        .halt_o      (halt)
    );

    // Reference model: stall bit, sticky status, and remaining run cycles
    // per core (0 = not stepping).
    bit [N-1:0] m_stall;
    bit [N-1:0] m_bpst;
    bit [N-1:0] m_xtm;
    int         m_rem [N];

    function automatic bit [N-1:0] m_run();
        bit [N-1:0] r;
        for (int n = 0; n < N; n++) r[n] = (m_rem[n] > 0);
        return r;
    endfunction

    function automatic bit [N-1:0] m_eff_stall();
        return bp | (m_stall & ~m_run());
    endfunction

    function automatic bit [N-1:0] m_rdata();
        case (addr)
            2'd0:    return m_stall;
            2'd1:    return m_bpst;
            2'd2:    return m_run();
            default: return m_eff_stall();
        endcase
    endfunction

    task automatic model_step();
        bit [N-1:0] hit;
        bit [N-1:0] ns;
        bit [N-1:0] nb;
        int         nr [N];
        if (rst) begin
            m_stall = '0;
            m_bpst  = '0;
            m_xtm   = '0;
            for (int n = 0; n < N; n++) m_rem[n] = 0;
            return;
        end
        hit = bp;
`ifdef DBG_CROSS_TRIGGER_EN
        if ((m_xtm & bp) != '0) hit = hit | m_xtm;
`endif
        for (int n = 0; n < N; n++) begin
            bit finishing;
            finishing = (m_rem[n] == 1) && !hit[n];
            if (hit[n] || finishing)          ns[n] = 1'b1;
            else if (we && addr == 2'd0)      ns[n] = wd[n];
            else                              ns[n] = m_stall[n];
            if (bp[n])                        nb[n] = 1'b1;
            else if (we && addr == 2'd1 && wd[n]) nb[n] = 1'b0;
            else                              nb[n] = m_bpst[n];
            if (m_rem[n] > 0)
                nr[n] = (hit[n] || m_rem[n] == 1) ? 0 : m_rem[n] - 1;
            else if (we && addr == 2'd2 && wd[n] && m_stall[n] && !hit[n])
                nr[n] = STEPS;
            else
                nr[n] = 0;
        end
`ifdef DBG_CROSS_TRIGGER_EN
        if (we && addr == 2'd3) m_xtm = wd;
`endif
        m_stall = ns;
        m_bpst  = nb;
        for (int n = 0; n < N; n++) m_rem[n] = nr[n];
    endtask

    task automatic apply(input bit r, input bit w, input bit [1:0] a,
                         input bit [N-1:0] d, input bit [N-1:0] b);
        @(negedge clk);
        rst  = r;
        we   = w;
        addr = a;
        wd   = d;
        bp   = b;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
    endtask

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " stall"}, stall_o, m_eff_stall());
        chk({tag, " busy"},  busy_o,  m_run());
        chk({tag, " halt"},  {{(N-1){1'b0}}, halt}, {{(N-1){1'b0}}, (m_bpst != '0)});
        chk({tag, " rdata"}, rdata,   m_rdata());
    endtask

    typedef struct {
        bit         rst;
        bit         we;
        bit [1:0]   addr;
        bit [N-1:0] wd;
        bit [N-1:0] bp;
        bit [N-1:0] e_stall;
        bit [N-1:0] e_busy;
        bit         e_halt;
        bit [N-1:0] e_rdata;
    } vec_t;

    vec_t tbl [22];

    initial begin
        // rst we addr wdata bp | stall busy halt rdata   (outputs before the edge)
        tbl[0]  = '{0, 1, 2'd0, 8'h05, 8'h00, 8'h00, 8'h00, 0, 8'h00};
        tbl[1]  = '{0, 0, 2'd0, 8'h00, 8'h00, 8'h05, 8'h00, 0, 8'h05};
        tbl[2]  = '{0, 0, 2'd1, 8'h00, 8'h08, 8'h0D, 8'h00, 0, 8'h00};
        tbl[3]  = '{0, 0, 2'd1, 8'h00, 8'h00, 8'h0D, 8'h00, 1, 8'h08};
        tbl[4]  = '{0, 1, 2'd1, 8'h08, 8'h00, 8'h0D, 8'h00, 1, 8'h08};
        tbl[5]  = '{0, 0, 2'd0, 8'h00, 8'h00, 8'h0D, 8'h00, 0, 8'h0D};
        tbl[6]  = '{0, 1, 2'd2, 8'h04, 8'h00, 8'h0D, 8'h00, 0, 8'h00};
        tbl[7]  = '{0, 0, 2'd2, 8'h00, 8'h00, 8'h09, 8'h04, 0, 8'h04};
        tbl[8]  = '{0, 0, 2'd3, 8'h00, 8'h00, 8'h09, 8'h04, 0, 8'h09};
        tbl[9]  = '{0, 0, 2'd0, 8'h00, 8'h00, 8'h09, 8'h04, 0, 8'h0D};
        tbl[10] = '{0, 0, 2'd0, 8'h00, 8'h00, 8'h0D, 8'h00, 0, 8'h0D};
        tbl[11] = '{0, 1, 2'd2, 8'h06, 8'h00, 8'h0D, 8'h00, 0, 8'h00};
        tbl[12] = '{0, 0, 2'd2, 8'h00, 8'h00, 8'h09, 8'h04, 0, 8'h04};
        tbl[13] = '{0, 0, 2'd1, 8'h00, 8'h04, 8'h0D, 8'h04, 0, 8'h00};
        tbl[14] = '{0, 0, 2'd1, 8'h00, 8'h00, 8'h0D, 8'h00, 1, 8'h04};
        tbl[15] = '{0, 1, 2'd1, 8'h01, 8'h01, 8'h0D, 8'h00, 1, 8'h04};
        tbl[16] = '{0, 0, 2'd1, 8'h00, 8'h00, 8'h0D, 8'h00, 1, 8'h05};
        tbl[17] = '{0, 1, 2'd2, 8'h01, 8'h00, 8'h0D, 8'h00, 1, 8'h00};
        tbl[18] = '{1, 0, 2'd2, 8'h00, 8'h00, 8'h0C, 8'h01, 1, 8'h01};
        tbl[19] = '{0, 0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'h00};
        tbl[20] = '{0, 1, 2'd3, 8'hFF, 8'h00, 8'h00, 8'h00, 0, 8'h00};
        tbl[21] = '{0, 0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'h00};

        rst = 1'b1; we = 1'b0; addr = 2'd0; wd = '0; bp = '0;
        for (int n = 0; n < N; n++) m_rem[n] = 0;
        m_stall = '0; m_bpst = '0; m_xtm = '0;

        apply(1, 0, 2'd0, '0, '0);
        tick();
        apply(1, 0, 2'd0, '0, '0);
        tick();

        // Reset state, every register readable as zero
        for (int a = 0; a < 4; a++) begin
            apply(0, 0, 2'(a), '0, '0);
            chk("reset stall", stall_o, '0);
            chk("reset busy", busy_o, '0);
            chk("reset halt", {{(N-1){1'b0}}, halt}, '0);
            chk("reset rdata", rdata, '0);
            tick();
        end

        // Directed vectors
        for (int i = 0; i < 22; i++) begin
            apply(tbl[i].rst, tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].bp);
            chk($sformatf("vec%0d stall", i), stall_o, tbl[i].e_stall);
            chk($sformatf("vec%0d busy", i), busy_o, tbl[i].e_busy);
            chk($sformatf("vec%0d halt", i), {{(N-1){1'b0}}, halt}, {{(N-1){1'b0}}, tbl[i].e_halt});
            chk($sformatf("vec%0d rdata", i), rdata, tbl[i].e_rdata);
            tick();
        end

        // STEP write to a core already in RUN is ignored; a STALL write in RUN
        // does not end the step and completion re-stalls the core.
        apply(0, 1, 2'd0, 8'h10, '0);
        tick();
        apply(0, 1, 2'd2, 8'h10, '0);
        tick();
        apply(0, 1, 2'd2, 8'h10, '0);
        chk("rerun busy", busy_o, 8'h10);
        tick();
        apply(0, 1, 2'd0, 8'h00, '0);
        chk("run stall masked", stall_o, 8'h00);
        tick();
        apply(0, 0, 2'd0, '0, '0);
        chk("run kept after stall write", busy_o, 8'h10);
        chk("stall_reg cleared in run", rdata, 8'h00);
        tick();
        apply(0, 0, 2'd0, '0, '0);
        chk("completion restalls", stall_o, 8'h10);
        chk("completion idle", busy_o, 8'h00);
        tick();

`ifdef DBG_CROSS_TRIGGER_EN
        apply(1, 0, 2'd0, '0, '0);
        tick();
        apply(0, 1, 2'd3, 8'h0F, '0);
        tick();
        apply(0, 0, 2'd0, '0, 8'h02);
        chk("xt comb stall", stall_o, 8'h02);
        tick();
        apply(0, 0, 2'd0, '0, '0);
        chk("xt stall_reg", rdata, 8'h0F);
        tick();
        apply(0, 0, 2'd1, '0, '0);
        chk("xt bpstat", rdata, 8'h02);
        chk("xt status", stall_o, 8'h0F);
        tick();
`endif

        // Randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            bit [N-1:0] rb;
            bit         rr;
            bit         rw;
            for (int n = 0; n < N; n++) rb[n] = ($urandom_range(0, 15) == 0);
            rr = ($urandom_range(0, 99) == 0);
            rw = ($urandom_range(0, 2) == 0);
            apply(rr, rw, 2'($urandom_range(0, 3)), N'($urandom), rb);
            chk_model($sformatf("rand%0d", i));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
